// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } muldiv_state_e;

    localparam int          MULDIV_ITER = 32;
    localparam logic [31:0] DIV0_QUOT   = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN     = 32'h8000_0000;

    // Magnitude of a 32-bit operand; INT_MIN maps to itself, read as unsigned.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic as_signed);
        return (as_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on
// unsigned magnitudes, 32 iterations, sign fixup in a final cycle.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Funct3,
    input  logic [31:0] OpA,
    input  logic [31:0] OpB,
    input  logic [4:0]  Rd,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Result,
    output logic [4:0]  RdOut,
    output logic        WrEn
);

    muldiv_state_e state_reg, state_next;
    muldiv_op_e    op_reg;
    logic [4:0]    rd_reg;
    logic [31:0]   m_reg;          // multiplicand or divisor
    logic [63:0]   acc_reg;        // product, or dividend/quotient in [31:0]
    logic [32:0]   rem_reg;
    logic          neg_reg;
    logic          div_zero_reg;
    logic [4:0]    cnt_reg;
    logic          done_reg;
    logic [31:0]   result_reg;
    logic [4:0]    rdout_reg;

    muldiv_op_e    op_in;
    logic          a_signed, b_signed, sign_in;
    logic [31:0]   a_mag, b_mag;
    logic          is_mul_in;

    logic [32:0]   mul_sum;
    logic [63:0]   mul_next;
    logic [33:0]   div_shift, div_diff;
    logic          div_ge;
    logic [32:0]   rem_next;
    logic [31:0]   quot_next;

    logic [63:0]   prod;
    logic [31:0]   quot, remv, fin_result;

    assign op_in     = muldiv_op_e'(Funct3);
    assign is_mul_in = ~Funct3[2];

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        sign_in  = 1'b0;
        case (op_in)
            OP_MULH, OP_DIV: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
                sign_in  = OpA[31] ^ OpB[31];
            end
            OP_MULHSU: begin
                a_signed = 1'b1;
                sign_in  = OpA[31];
            end
            OP_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
                sign_in  = OpA[31];
            end
            default: ;
        endcase
    end

    assign a_mag = mag32(OpA, a_signed);
    assign b_mag = mag32(OpB, b_signed);

    // Multiply step: add multiplicand into the high half when the low bit is set,
    // then shift the whole 65-bit {carry, acc} right by one.
    assign mul_sum  = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, m_reg} : 33'd0);
    assign mul_next = {mul_sum, acc_reg[31:1]};

    // Restoring divide step: shift in the next dividend bit, subtract if it fits.
    assign div_shift = {rem_reg, acc_reg[31]};
    assign div_diff  = div_shift - {2'b00, m_reg};
    assign div_ge    = ~div_diff[33];
    assign rem_next  = div_ge ? div_diff[32:0] : div_shift[32:0];
    assign quot_next = {acc_reg[30:0], div_ge};

    // Division by zero leaves |A| as the remainder, so the dividend-sign fixup
    // already reproduces OpA; only the quotient needs an explicit override.
    assign prod = neg_reg ? (64'd0 - acc_reg) : acc_reg;
    assign quot = neg_reg ? (32'd0 - acc_reg[31:0]) : acc_reg[31:0];
    assign remv = neg_reg ? (32'd0 - rem_reg[31:0]) : rem_reg[31:0];

    always_comb begin
        fin_result = 32'd0;
        case (op_reg)
            OP_MUL:                      fin_result = prod[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_result = prod[63:32];
            OP_DIV, OP_DIVU:             fin_result = div_zero_reg ? DIV0_QUOT : quot;
            default:                     fin_result = remv;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (Start) state_next = CALC;
            CALC: if (cnt_reg == 5'(MULDIV_ITER - 1)) state_next = FIN;
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            op_reg       <= OP_MUL;
            rd_reg       <= 5'd0;
            m_reg        <= 32'd0;
            acc_reg      <= 64'd0;
            rem_reg      <= 33'd0;
            neg_reg      <= 1'b0;
            div_zero_reg <= 1'b0;
            cnt_reg      <= 5'd0;
            done_reg     <= 1'b0;
            result_reg   <= 32'd0;
            rdout_reg    <= 5'd0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (Start) begin
                        op_reg       <= op_in;
                        rd_reg       <= Rd;
                        m_reg        <= is_mul_in ? a_mag : b_mag;
                        acc_reg      <= {32'd0, is_mul_in ? b_mag : a_mag};
                        rem_reg      <= 33'd0;
                        neg_reg      <= sign_in;
                        div_zero_reg <= (OpB == 32'd0);
                        cnt_reg      <= 5'd0;
                    end
                end
                CALC: begin
                    cnt_reg <= cnt_reg + 5'd1;
                    if (op_reg[2]) begin
                        acc_reg <= {acc_reg[63:32], quot_next};
                        rem_reg <= rem_next;
                    end else begin
                        acc_reg <= mul_next;
                    end
                end
                FIN: begin
                    result_reg <= fin_result;
                    rdout_reg  <= rd_reg;
                    done_reg   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Busy   = (state_reg != IDLE);
    assign Done   = done_reg;
    assign Result = result_reg;
    assign RdOut  = rdout_reg;
    assign WrEn   = done_reg && (rdout_reg != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus control-path sequences.
module tb_muldiv_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [2:0]  Funct3;
    logic [31:0] OpA, OpB;
    logic [4:0]  Rd;
    logic        Busy, Done, WrEn;
    logic [31:0] Result;
    logic [4:0]  RdOut;

    int checks_total  = 0;
    int checks_passed = 0;

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    muldiv_unit dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Start  (Start),
        .Funct3 (Funct3),
        .OpA    (OpA),
        .OpB    (OpB),
        .Rd     (Rd),
        .Busy   (Busy),
        .Done   (Done),
        .Result (Result),
        .RdOut  (RdOut),
        .WrEn   (WrEn)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive Start on the falling edge; returns just after the accepting edge.
    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
        @(negedge Clk);
        Funct3 = f;
        OpA    = a;
        OpB    = b;
        Rd     = rd;
        Start  = 1'b1;
        @(posedge Clk);
        #1;
        Start  = 1'b0;
    endtask

    // Counts edges until Done is seen, starting from an already elapsed count.
    task automatic wait_done(input int already, output int cycles);
        cycles = already;
        while (cycles < 60) begin
            @(posedge Clk);
            #1;
            cycles++;
            if (Done) break;
        end
    endtask

    initial begin
        int n;
        int saw_done;

        vecs[0]  = '{"mul_7x-3",      3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
        vecs[1]  = '{"mulh_min_min",  3'b001, 32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000};
        vecs[2]  = '{"mulhu_max_max", 3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE};
        vecs[3]  = '{"mulhsu_-1x2",   3'b010, 32'hFFFF_FFFF,  32'd2,         5'd3,  32'hFFFF_FFFF};
        vecs[4]  = '{"div_-7/2",      3'b100, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD};
        vecs[5]  = '{"rem_-7/2",      3'b110, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF};
        vecs[6]  = '{"divu_100/7",    3'b101, 32'd100,        32'd7,         5'd7,  32'd14};
        vecs[7]  = '{"remu_100/7",    3'b111, 32'd100,        32'd7,         5'd8,  32'd2};
        vecs[8]  = '{"divu_5/0",      3'b101, 32'd5,          32'd0,         5'd9,  32'hFFFF_FFFF};
        vecs[9]  = '{"remu_5/0",      3'b111, 32'd5,          32'd0,         5'd10, 32'd5};
        vecs[10] = '{"div_-5/0",      3'b100, 32'hFFFF_FFFB,  32'd0,         5'd11, 32'hFFFF_FFFF};
        vecs[11] = '{"rem_-5/0",      3'b110, 32'hFFFF_FFFB,  32'd0,         5'd12, 32'hFFFF_FFFB};
        vecs[12] = '{"div_min/-1",    3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'h8000_0000};
        vecs[13] = '{"rem_min/-1",    3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'd0};
        vecs[14] = '{"mul_rd0",       3'b000, 32'd6,          32'd7,         5'd0,  32'd42};
        vecs[15] = '{"mulh_-3x7",     3'b001, 32'hFFFF_FFFD,  32'd7,         5'd31, 32'hFFFF_FFFF};

        Reset  = 1'b1;
        Start  = 1'b0;
        Funct3 = 3'd0;
        OpA    = 32'd0;
        OpB    = 32'd0;
        Rd     = 5'd0;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_busy",   32'(Busy),   32'd0);
        chk("reset_done",   32'(Done),   32'd0);
        chk("reset_wren",   32'(WrEn),   32'd0);
        chk("reset_result", Result,      32'd0);
        chk("reset_rdout",  32'(RdOut),  32'd0);
        @(negedge Clk);
        Reset = 1'b0;

        foreach (vecs[i]) begin
            start_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd);
            chk({vecs[i].name, "_busy"}, 32'(Busy), 32'd1);
            wait_done(0, n);
            $display("op %-14s a=%08h b=%08h rd=%0d -> result=%08h rdout=%0d wren=%0b after %0d cycles",
                     vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].rd, Result, RdOut, WrEn, n);
            chk({vecs[i].name, "_latency"}, 32'(n),     32'd33);
            chk({vecs[i].name, "_result"},  Result,     vecs[i].exp);
            chk({vecs[i].name, "_rdout"},   32'(RdOut), 32'(vecs[i].rd));
            chk({vecs[i].name, "_wren"},    32'(WrEn),  32'(vecs[i].rd != 5'd0));
            chk({vecs[i].name, "_notbusy"}, 32'(Busy),  32'd0);
            @(posedge Clk);
            #1;
            chk({vecs[i].name, "_donefall"}, 32'(Done), 32'd0);
        end

        // Start while busy must be ignored entirely.
        start_op(3'b101, 32'd1000, 32'd10, 5'd20);
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        Funct3 = 3'b000;
        OpA    = 32'd9;
        OpB    = 32'd9;
        Rd     = 5'd21;
        Start  = 1'b1;
        @(posedge Clk);
        #1;
        Start  = 1'b0;
        wait_done(6, n);
        $display("op ignore_start  divu 1000/10 rd=20 -> result=%08h rdout=%0d after %0d cycles", Result, RdOut, n);
        chk("ignore_latency", 32'(n),     32'd33);
        chk("ignore_result",  Result,     32'd100);
        chk("ignore_rdout",   32'(RdOut), 32'd20);

        // Back-to-back: Start presented during the Done cycle.
        start_op(3'b000, 32'd11, 32'd13, 5'd3);
        chk("b2b_done_falls", 32'(Done), 32'd0);
        chk("b2b_busy",       32'(Busy), 32'd1);
        wait_done(0, n);
        $display("op b2b_mul       11*13 rd=3 -> result=%08h rdout=%0d after %0d cycles", Result, RdOut, n);
        chk("b2b_latency", 32'(n),     32'd33);
        chk("b2b_result",  Result,     32'd143);
        chk("b2b_rdout",   32'(RdOut), 32'd3);

        // Reset mid-operation aborts with no Done.
        start_op(3'b011, 32'd50, 32'd60, 5'd9);
        repeat (10) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        chk("abort_busy",   32'(Busy),  32'd0);
        chk("abort_done",   32'(Done),  32'd0);
        chk("abort_result", Result,     32'd0);
        chk("abort_rdout",  32'(RdOut), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        saw_done = 0;
        repeat (40) begin
            @(posedge Clk);
            #1;
            if (Done) saw_done = 1;
        end
        $display("op abort         reset at cycle 10 -> done seen=%0d", saw_done);
        chk("abort_no_done", 32'(saw_done), 32'd0);
        start_op(3'b000, 32'd3, 32'd4, 5'd1);
        wait_done(0, n);
        $display("op after_reset   3*4 rd=1 -> result=%08h after %0d cycles", Result, n);
        chk("post_reset_latency", 32'(n), 32'd33);
        chk("post_reset_result",  Result, 32'd12);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit. Takes the two register operands read from the register file, computes one of the eight M-extension operations over a fixed multi-cycle latency, and returns a result with destination index and write strobe that drive the register file write port (D, addrD, Load) through writeback. The integer pipeline holds while Busy is high.

## Interface
- No parameters; datapath fixed at 32 bits, iteration count fixed at 32.
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- Start  in  1  request; accepted only on a rising edge where Busy=0.
- Funct3  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- OpA  in  32  rs1 value (register file dataA).
- OpB  in  32  rs2 value (register file dataB).
- Rd  in  5  destination register index.
- Busy  out  1  operation in flight; Start ignored.
- Done  out  1  one-cycle pulse; Result and RdOut valid.
- Result  out  32  registered result; holds until the next completion.
- RdOut  out  5  Rd captured at accept.
- WrEn  out  1  Done && (RdOut != 0); drives register file Load.

## Operation
- States: IDLE, CALC, FIN.
- IDLE: on Start, latch Funct3, Rd, |OpA|, |OpB|, and the result sign. Clear the 5-bit counter and go to CALC.
- Signedness of operands:
  - MULH, DIV, REM: both signed.
  - MULHSU: A signed, B unsigned.
  - MUL, MULHU, DIVU, REMU: magnitudes used directly.
- CALC, multiply: unsigned shift-add, one multiplier bit per cycle, into a 64-bit accumulator.
- CALC, divide: unsigned restoring division, one quotient bit per cycle, with a 33-bit partial remainder.
- CALC: the counter increments every cycle. At count 31 go to FIN.
- FIN: apply the sign fixup and select the result, register Result and RdOut, pulse Done, and return to IDLE.
- Multiply result selection:
  - 64-bit product is negated if the sign is negative.
  - MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].
- Divide sign rules:
  - DIV quotient sign = sign(A) xor sign(B).
  - REM remainder takes the sign of the dividend.
- Divide by zero, overriding the fixup:
  - DIV/DIVU quotient = 0xFFFFFFFF.
  - REM/REMU = OpA.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, REM 0. Latency is unchanged.
- All special cases take the full fixed latency; there is no early-out.
- Start while Busy is ignored completely: no operand, Funct3 or Rd capture.
- Rd=0: the operation runs normally and Done pulses, but WrEn stays 0.

## Timing
- Reset values: state IDLE, Busy 0, Done 0, WrEn 0, Result 0, RdOut 0, counter 0.
- Reset asserted mid-operation aborts immediately to the reset values. No Done is produced for the aborted op.
- For a Start accepted at edge k:
  - Busy=1 from edge k to edge k+33.
  - Iterations run on edges k+1..k+32.
  - FIN is occupied between edges k+32 and k+33.
  - At edge k+33: Done=1, WrEn per Rd, Result valid, Busy=0.
  - Done falls at edge k+34.
- Latency: 33 cycles from accept to Done for every op.
- Back-to-back: a Start during the Done cycle is accepted at edge k+34. Throughput is one op per 34 cycles.
- Result/RdOut are stable from Done until the next completion, so writeback may sample one cycle late.

## Structure
- Package muldiv_pkg holds:
  - enum muldiv_op_e for the Funct3 encodings.
  - enum muldiv_state_e {IDLE, CALC, FIN}.
  - Constant MULDIV_ITER = 32.
  - Constants DIV0_QUOT = 32'hFFFFFFFF and INT_MIN = 32'h80000000.
- Single module; no sub-module is warranted. Multiply and divide share the operand registers, counter and FSM.

## Test plan
- MUL: OpA=7, OpB=0xFFFFFFFD (-3), Rd=5 -> Done exactly 33 cycles after accept, Result=0xFFFFFFEB, RdOut=5, WrEn=1.
- High-half multiplies:
  - MULH 0x80000000 × 0x80000000 -> Result=0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF -> Result=0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 -> Result=0xFFFFFFFF.
- Signed divide and remainder: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases:
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV -5/0 -> 0xFFFFFFFF; REM -5/0 -> 0xFFFFFFFB.
  - DIV 0x80000000/-1 -> 0x80000000; REM 0x80000000/-1 -> 0.
  - All take 33 cycles.
- Control:
  - Start pulsed mid-operation with different operands -> ignored, and the original result is returned.
  - Start during the Done cycle -> accepted, and its Done follows 33 cycles later.
  - Rd=0 -> Done=1, WrEn=0.
- Reset asserted at cycle 10 of an operation -> Busy, Done, Result and RdOut all 0 at once, and no Done appears. A fresh MUL 3×4 then returns 12.
